// File: rtl/rx_port_arb_pkg.sv
// rtl/rx_port_arb_pkg.sv - shared widths and FSM encoding for the receive port arbiter
package rx_port_arb_pkg;

    localparam int XGMII_W = 64;
    localparam int MOD_W   = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_XFER  = 2'd1,
        ARB_FLUSH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rx_port_arb_if.sv
// rtl/rx_port_arb_if.sv - per-port FIFO heads in, merged frame stream out
// Port summary:
//   PortVld/PortRxd/PortSof/PortEof/PortMod/PortErr : show-ahead FIFO heads, one lane per port
//   PortRd                                          : pop strobes back to the FIFOs
//   ArbRdy                                          : downstream accepts a beat next cycle
//   ArbRxdv/ArbRxd/ArbRxSof/ArbRxEof/ArbRxMod/ArbErr/ArbPort : merged, port-tagged stream
//   SyncErr                                         : stray beat discarded
// master = FIFO side plus downstream sink, slave = arbiter.
interface rx_port_arb_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
);
    import rx_port_arb_pkg::*;

    logic [NUM_PORTS-1:0]         PortVld;
    logic [XGMII_W*NUM_PORTS-1:0] PortRxd;
    logic [NUM_PORTS-1:0]         PortSof;
    logic [NUM_PORTS-1:0]         PortEof;
    logic [MOD_W*NUM_PORTS-1:0]   PortMod;
    logic [NUM_PORTS-1:0]         PortErr;
    logic [NUM_PORTS-1:0]         PortRd;
    logic                         ArbRdy;
    logic                         ArbRxdv;
    logic [XGMII_W-1:0]           ArbRxd;
    logic                         ArbRxSof;
    logic                         ArbRxEof;
    logic [MOD_W-1:0]             ArbRxMod;
    logic                         ArbErr;
    logic [PORT_W-1:0]            ArbPort;
    logic                         SyncErr;

    modport master (
        output PortVld, PortRxd, PortSof, PortEof, PortMod, PortErr, ArbRdy,
        input  PortRd, ArbRxdv, ArbRxd, ArbRxSof, ArbRxEof, ArbRxMod, ArbErr, ArbPort, SyncErr
    );

    modport slave (
        input  PortVld, PortRxd, PortSof, PortEof, PortMod, PortErr, ArbRdy,
        output PortRd, ArbRxdv, ArbRxd, ArbRxSof, ArbRxEof, ArbRxMod, ArbErr, ArbPort, SyncErr
    );

endinterface

// File: rtl/rx_port_arb_rr_pick.sv
// rtl/rx_port_arb_rr_pick.sv - combinational round-robin pick starting at a pointer
// Ports:
//   req_i : request vector
//   ptr_i : index that has highest priority this cycle
//   gnt_o : one-hot grant
//   idx_o : grant index
//   any_o : at least one request present
module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PORT_W-1:0]    idx_o,
    output logic                 any_o
);

    int  j;
    logic found;

    // Walk from the pointer upward with wrap-around; the first request wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PORT_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/rx_port_arb.sv
// rtl/rx_port_arb.sv - packet-granular round-robin merge of per-port receive streams
// Ports:
//   Clk   : clock
//   Reset : asynchronous, active-high reset
//   rx_if : slave side of rx_port_arb_if (FIFO heads in, PortRd out, tagged stream out)
module rx_port_arb
    import rx_port_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2,
    parameter int MAX_BEATS = 1200,
    parameter int CNT_W     = 11
) (
    input  logic         Clk,
    input  logic         Reset,
    rx_port_arb_if.slave rx_if
);

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0]  SAT_CNT   = CNT_W'(MAX_BEATS);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    arb_state_e            state_q, state_d;
    logic [PORT_W-1:0]     ptr_q, ptr_d;
    logic [PORT_W-1:0]     grant_q, grant_d;
    logic [NUM_PORTS-1:0]  gnt_oh_q, gnt_oh_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_PORTS-1:0]  cand, stray, stray_oh;
    logic [NUM_PORTS-1:0]  pick_gnt;
    logic [PORT_W-1:0]     pick_idx;
    logic                  pick_any;

    logic [XGMII_W-1:0]    sel_rxd;
    logic [MOD_W-1:0]      sel_mod;
    logic                  sel_vld, sel_sof, sel_eof, sel_err;

    logic [NUM_PORTS-1:0]  port_rd;
    logic                  pop, fwd, stray_pop;
    logic                  at_limit, trunc;
    logic [PORT_W-1:0]     ptr_next;
    logic [CNT_W-1:0]      cnt_inc;

    logic                  rxdv_q, sof_q, eof_q, err_q, sync_q;
    logic [XGMII_W-1:0]    rxd_q;
    logic [MOD_W-1:0]      mod_q;
    logic [PORT_W-1:0]     port_q;

    // A head without SOF seen between frames can never start a frame; it is a stray.
    assign cand     = rx_if.PortVld & rx_if.PortSof;
    assign stray    = rx_if.PortVld & ~rx_if.PortSof;
    assign stray_oh = stray & (~stray + NUM_PORTS'(1));

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_pick (
        .req_i (cand),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Head of the granted port.
    assign sel_rxd = rx_if.PortRxd[grant_q*XGMII_W +: XGMII_W];
    assign sel_mod = rx_if.PortMod[grant_q*MOD_W +: MOD_W];
    assign sel_vld = rx_if.PortVld[grant_q];
    assign sel_sof = rx_if.PortSof[grant_q];
    assign sel_eof = rx_if.PortEof[grant_q];
    assign sel_err = rx_if.PortErr[grant_q];

    assign ptr_next = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
    assign cnt_inc  = (cnt_q == SAT_CNT) ? cnt_q : cnt_q + 1'b1;
    assign at_limit = (cnt_q == LAST_CNT);
    // An EOF landing on the limit is a normal end, so only non-EOF beats truncate.
    assign trunc    = fwd & ~sel_eof & at_limit;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            gnt_oh_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            gnt_oh_q <= gnt_oh_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        gnt_oh_d = gnt_oh_q;
        cnt_d    = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d  = ARB_XFER;
                    grant_d  = pick_idx;
                    gnt_oh_d = pick_gnt;
                    cnt_d    = '0;
                end
            end
            ARB_XFER: begin
                if (pop) begin
                    if (sel_eof) begin
                        state_d = ARB_IDLE;
                        ptr_d   = ptr_next;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (at_limit) begin
                            state_d = ARB_FLUSH;
                        end
                    end
                end
            end
            ARB_FLUSH: begin
                if (pop && sel_eof) begin
                    state_d = ARB_IDLE;
                    ptr_d   = ptr_next;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Pop strobes. IDLE only drains strays; the granted port is popped from the next cycle.
    always_comb begin
        port_rd   = '0;
        pop       = 1'b0;
        fwd       = 1'b0;
        stray_pop = 1'b0;
        if (!Reset) begin
            case (state_q)
                ARB_IDLE: begin
                    if (|stray) begin
                        port_rd   = stray_oh;
                        stray_pop = 1'b1;
                    end
                end
                ARB_XFER: begin
                    if (sel_vld && rx_if.ArbRdy) begin
                        port_rd = gnt_oh_q;
                        pop     = 1'b1;
                        fwd     = 1'b1;
                    end
                end
                ARB_FLUSH: begin
                    if (sel_vld) begin
                        port_rd = gnt_oh_q;
                        pop     = 1'b1;
                    end
                end
                default: begin
                    port_rd = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rxdv_q <= 1'b0;
            rxd_q  <= '0;
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
            mod_q  <= '0;
            err_q  <= 1'b0;
            port_q <= '0;
            sync_q <= 1'b0;
        end else begin
            rxdv_q <= fwd;
            rxd_q  <= fwd ? sel_rxd : '0;
            sof_q  <= fwd & sel_sof;
            eof_q  <= fwd & (sel_eof | at_limit);
            mod_q  <= (fwd && !trunc) ? sel_mod : '0;
            err_q  <= trunc | (fwd & sel_sof & sel_err);
            port_q <= fwd ? grant_q : '0;
            sync_q <= stray_pop;
        end
    end

    assign rx_if.PortRd   = port_rd;
    assign rx_if.ArbRxdv  = rxdv_q;
    assign rx_if.ArbRxd   = rxd_q;
    assign rx_if.ArbRxSof = sof_q;
    assign rx_if.ArbRxEof = eof_q;
    assign rx_if.ArbRxMod = mod_q;
    assign rx_if.ArbErr   = err_q;
    assign rx_if.ArbPort  = port_q;
    assign rx_if.SyncErr  = sync_q;

endmodule
